mul8_shift_add: RTL
===================

Name: mul8_shift_add

Overview:
- Sequential unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Built around one WIDTH-bit ripple adder with carry-out: one conditional add plus right shift per cycle.
- Sits directly downstream of the operand path and consumes the adder's sum/carry each cycle.
- Ready/valid handshakes on input and output so it drops into the datapath between register stages.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  a*b
- hi_nz  out  1  product[2*WIDTH-1:WIDTH] != 0, meaning the result does not fit in WIDTH bits

Behaviour:
- Reset, asserted asynchronously, takes effect immediately regardless of state:
  - state=IDLE
  - in_ready=1, out_valid=0, product=0, hi_nz=0
  - internal regs: A=0, P=0, Q=0, cnt=0
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1: A<=a, Q<=b, P<=0, cnt<=WIDTH, go RUN.
  - in_ready=0 in every state except IDLE.
- RUN, one iteration per edge:
  - {c,s} = P + (Q[0] ? A : 0), carry-in 0, WIDTH-bit add with carry-out c.
  - {P,Q} <= {c,s,Q} >> 1; cnt <= cnt-1.
  - When cnt==1 on this edge: go DONE.
  - a/b changes during RUN are ignored.
- DONE:
  - out_valid=1, product={P,Q}, hi_nz=|P.
  - Product holds stable while out_ready=0.
  - On edge with out_ready=1: go IDLE, out_valid<=0.
- Latency: accepting edge k puts the block in RUN. Iterations run on edges k+1..k+WIDTH. out_valid is 1 after edge k+WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles when out_ready is held 1.
- No simultaneous accept/retire: a new operand is only accepted in IDLE, the cycle after retirement.
- Arithmetic:
  - Carry out of the add is never lost; it becomes P's MSB after the shift.
  - Product is exact for all operands; 2*WIDTH bits never overflow.
- Boundaries:
  - a=0 or b=0: product=0, hi_nz=0, same latency.
  - a=b=2^WIDTH-1: carry out asserted on most iterations; product=(2^WIDTH-1)^2.
  - in_valid held high across DONE is not accepted until IDLE.
  - Reset during RUN or DONE aborts the operation, no partial product is output, and the block returns to IDLE with in_ready=1 after release.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined:
  - In RUN, if the remaining unprocessed multiplier bits Q[cnt-1:0] are all zero, the block finishes that edge.
  - {P,Q} <= {P,Q} >> cnt, cnt<=0, go DONE.
  - The product value is identical to the full run.
  - Latency becomes (index of highest set bit of b)+1 edges; b=0 finishes on the first RUN edge.
- Undefined: fixed WIDTH-edge latency as above; no shifter logic is synthesized.

Test Plan:
- rst_n pulse mid-idle -> in_ready=1, out_valid=0, product=0x0000 immediately, without waiting for a clock edge.
- a=0x0F, b=0x0F, out_ready=1 -> out_valid 8 edges after accept, product=0x00E1, hi_nz=0. With MUL_EARLY_TERM_EN: after 4 edges.
- a=0xFF, b=0xFF -> product=0xFE01, hi_nz=1. a=0x00, b=0xA5 -> product=0x0000, hi_nz=0.
- a=0x12, b=0x34, out_ready=0 for 5 cycles after out_valid -> product holds 0x03A8, in_ready stays 0; out_ready=1 -> IDLE next edge.
- Back-to-back: in_valid held 1 with pairs (0x80,0x02) then (0x03,0x07) -> products 0x0100 then 0x0015; second accept one cycle after first retire.
- Assert rst_n=0 at RUN iteration 4 of (0xAA,0x55), release, then send (0x02,0x03) -> no out_valid for the aborted op; product=0x0006.

Source files
------------

// File: rtl/mul8_shift_add.sv
// Sequential unsigned shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH) with ready/valid handshakes.
// Define MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module mul8_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 hi_nz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, p_reg, q_reg;
  logic [CW-1:0]        cnt_reg;

  logic [WIDTH-1:0]     addend, sum;
  logic [WIDTH:0]       carry;
  logic [2*WIDTH-1:0]   pq_shift, pq_final;
  logic [CW-1:0]        cnt_dec;
  logic                 last_iter;

  // One ripple adder: P + (Q[0] ? A : 0), carry-in 0.
  assign addend   = q_reg[0] ? a_reg : '0;
  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum[gi]     = p_reg[gi] ^ addend[gi] ^ carry[gi];
      assign carry[gi+1] = (p_reg[gi] & addend[gi]) | (carry[gi] & (p_reg[gi] ^ addend[gi]));
    end
  endgenerate

  // The carry-out lands in P's MSB after the right shift.
  assign pq_shift = {carry[WIDTH], sum, q_reg[WIDTH-1:1]};
  assign cnt_dec  = cnt_reg - 1'b1;

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;

  // After this iteration the unprocessed multiplier bits are pq_shift[cnt_dec-1:0].
  assign rem_mask  = ~({WIDTH{1'b1}} << cnt_dec);
  assign last_iter = ((pq_shift[WIDTH-1:0] & rem_mask) == '0);
  assign pq_final  = pq_shift >> cnt_dec;
`else
  assign last_iter = (cnt_reg == CW'(1));
  assign pq_final  = pq_shift;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    product   = '0;
    hi_nz     = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        product   = {p_reg, q_reg};
        hi_nz     = |p_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      p_reg   <= '0;
      q_reg   <= '0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            q_reg   <= b;
            p_reg   <= '0;
            cnt_reg <= CW'(WIDTH);
          end
        end
        RUN: begin
          {p_reg, q_reg} <= last_iter ? pq_final : pq_shift;
          cnt_reg        <= last_iter ? '0 : cnt_dec;
        end
        default: ;
      endcase
    end
  end

endmodule
